// File: rtl/pc_unit_if.sv
// Fetch-stage bus between the pipeline control and pc_unit.
// The master side drives redirect requests, and the slave side returns the PC and RAS status.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 16
);
    logic             stall;
    logic             exc;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic             jmp;
    logic [WIDTH-1:0] jmp_target;
    logic             call;
    logic [WIDTH-1:0] link_addr;
    logic             ret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic             flush;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_ovf;
    logic             ras_unf;

    modport master (
        output stall, exc, br_taken, br_target, jmp, jmp_target, call, link_addr, ret,
        input  pc, pc_next, flush, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, exc, br_taken, br_target, jmp, jmp_target, call, link_addr, ret,
        output pc, pc_next, flush, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter with fixed-priority redirects and a circular return-address stack.
module pc_unit #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned STEP      = 1,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned EXC_VEC   = 32'h0008,
    parameter int unsigned RAS_DEPTH = 4
) (
    input logic     clk,
    input logic     rst,
    pc_unit_if.slave bus
);
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);

    typedef enum logic [2:0] {SelSeq, SelExc, SelStall, SelBr, SelRet, SelJmp} sel_e;

    sel_e             sel;
    logic [WIDTH-1:0] pc_q, pc_d, pc_inc, ras_top;
    logic [PtrW-1:0]  top_q, top_d;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic             flush_q, flush_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push;
    logic             empty, full;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    assign pc_inc  = pc_q + WIDTH'(STEP);
    assign ras_top = ras_q[top_q];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PtrW+1)'(RAS_DEPTH));

    // Fixed-priority source selection; only the selected request is accepted.
    always_comb begin
        sel = SelSeq;
        if (bus.exc)           sel = SelExc;
        else if (bus.stall)    sel = SelStall;
        else if (bus.br_taken) sel = SelBr;
        else if (bus.ret)      sel = SelRet;
        else if (bus.jmp)      sel = SelJmp;
    end

    // Next PC, RAS pointer/count and status pulses for the selected source.
    always_comb begin
        pc_d    = pc_inc;
        top_d   = top_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        flush_d = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        unique case (sel)
            SelExc: begin
                pc_d    = WIDTH'(EXC_VEC);
                flush_d = 1'b1;
            end
            SelStall: pc_d = pc_q;
            SelBr: begin
                pc_d    = bus.br_target;
                flush_d = 1'b1;
            end
            SelRet: begin
                flush_d = 1'b1;
                if (empty) begin
                    // Underflow falls through to the sequential address.
                    unf_d = 1'b1;
                end else begin
                    pc_d  = ras_top;
                    top_d = top_q - PtrW'(1);
                    cnt_d = cnt_q - (PtrW+1)'(1);
                end
            end
            SelJmp: begin
                pc_d    = bus.jmp_target;
                flush_d = 1'b1;
                if (bus.call) begin
                    push  = 1'b1;
                    top_d = top_q + PtrW'(1);
                    // When full, the advancing pointer lands on the oldest entry.
                    if (full) ovf_d = 1'b1;
                    else      cnt_d = cnt_q + (PtrW+1)'(1);
                end
            end
            default: ;
        endcase
    end

    // Control state; reset clears everything except RAS contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= WIDTH'(RESET_VEC);
            top_q   <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // RAS storage; the contents are never read while the count is zero, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) ras_q[top_d] <= bus.link_addr;
    end

    assign bus.pc        = pc_q;
    assign bus.pc_next   = pc_d;
    assign bus.flush     = flush_q;
    assign bus.ras_empty = empty;
    assign bus.ras_full  = full;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with default parameters (16-bit, STEP 1, EXC_VEC 0x0008, RAS depth 4).
module tb_pc_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    pc_unit_if #(.WIDTH(16)) bus ();

    pc_unit #(
        .WIDTH(16), .STEP(1), .RESET_VEC(0), .EXC_VEC(32'h0008), .RAS_DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        bus.stall = 0; bus.exc = 0; bus.br_taken = 0; bus.br_target = '0;
        bus.jmp = 0; bus.jmp_target = '0; bus.call = 0; bus.link_addr = '0; bus.ret = 0;
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] tgt, input logic [15:0] link);
        clr();
        bus.jmp = 1; bus.call = 1; bus.jmp_target = tgt; bus.link_addr = link;
        tick();
        clr();
    endtask

    task automatic pop();
        clr();
        bus.ret = 1;
        tick();
        clr();
    endtask

    initial begin
        clr();
        #3;
        check("rst_pc", bus.pc, 0);
        check("rst_flush", bus.flush, 0);
        check("rst_empty", bus.ras_empty, 1);
        check("rst_full", bus.ras_full, 0);
        check("rst_ovf_unf", {bus.ras_ovf, bus.ras_unf}, 0);
        @(negedge clk);
        rst = 1;

        // Sequential fetch.
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("seq_pc", bus.pc, i);
            check("seq_flush", bus.flush, 0);
            check("seq_empty", bus.ras_empty, 1);
        end

        // Stall blocks a branch, exception overrides stall.
        bus.stall = 1; bus.br_taken = 1; bus.br_target = 16'h0040;
        #1 check("stall_pcnext", bus.pc_next, 5);
        repeat (2) begin
            tick();
            check("stall_pc", bus.pc, 5);
            check("stall_flush", bus.flush, 0);
        end
        bus.exc = 1;
        #1 check("exc_pcnext", bus.pc_next, 16'h0008);
        tick();
        clr();
        check("exc_pc", bus.pc, 16'h0008);
        check("exc_flush", bus.flush, 1);
        tick();
        check("exc_flush_drop", bus.flush, 0);
        check("exc_seq", bus.pc, 16'h0009);

        // Call without jmp is ignored.
        bus.call = 1; bus.link_addr = 16'h0099;
        tick();
        clr();
        check("call_only_pc", bus.pc, 16'h000A);
        check("call_only_empty", bus.ras_empty, 1);

        // RAS round trip.
        push(16'h0050, 16'h0011);
        check("push1_pc", bus.pc, 16'h0050);
        check("push1_flush", bus.flush, 1);
        push(16'h0060, 16'h0022);
        push(16'h0070, 16'h0033);
        check("push3_empty", bus.ras_empty, 0);
        pop();
        check("pop1", bus.pc, 16'h0033);
        pop();
        check("pop2", bus.pc, 16'h0022);
        pop();
        check("pop3", bus.pc, 16'h0011);
        check("pop3_empty", bus.ras_empty, 1);
        check("pop3_unf", bus.ras_unf, 0);
        tick();
        check("pre_unf_pc", bus.pc, 16'h0012);
        bus.ret = 1;
        #1 check("unf_pcnext", bus.pc_next, 16'h0013);
        tick();
        clr();
        check("unf_pc", bus.pc, 16'h0013);
        check("unf_pulse", bus.ras_unf, 1);
        check("unf_flush", bus.flush, 1);
        tick();
        check("unf_clear", bus.ras_unf, 0);
        check("unf_seq", bus.pc, 16'h0014);

        // Priority: branch beats ret and jmp, RAS untouched.
        push(16'h0080, 16'h0300);
        bus.br_taken = 1; bus.br_target = 16'h0100; bus.jmp = 1; bus.jmp_target = 16'h0200;
        bus.ret = 1; bus.call = 1; bus.link_addr = 16'h0555;
        tick();
        clr();
        check("prio_pc", bus.pc, 16'h0100);
        check("prio_empty", bus.ras_empty, 0);
        // Exception with ret leaves the RAS alone.
        bus.exc = 1; bus.ret = 1;
        tick();
        clr();
        check("exc_ret_pc", bus.pc, 16'h0008);
        // Stall with ret blocks the pop.
        bus.stall = 1; bus.ret = 1;
        tick();
        clr();
        check("stall_ret_pc", bus.pc, 16'h0008);
        // ret+jmp+call: pop only.
        bus.ret = 1; bus.jmp = 1; bus.call = 1; bus.jmp_target = 16'h0200;
        bus.link_addr = 16'h0777;
        tick();
        clr();
        check("ret_jmp_call_pc", bus.pc, 16'h0300);
        check("ret_jmp_call_empty", bus.ras_empty, 1);

        // Overflow.
        for (int i = 1; i <= 5; i++) begin
            push(16'h0010, 16'h00A0 + 16'(i));
            check("ovf_full", bus.ras_full, (i >= 4) ? 1 : 0);
            check("ovf_pulse", bus.ras_ovf, (i == 5) ? 1 : 0);
        end
        for (int i = 5; i >= 2; i--) begin
            pop();
            check("ovf_pop", bus.pc, 16'h00A0 + 16'(i));
            check("ovf_pop_ovf", bus.ras_ovf, 0);
        end
        check("ovf_empty", bus.ras_empty, 1);

        // Wrap and asynchronous reset.
        bus.jmp = 1; bus.jmp_target = 16'hFFFF;
        tick();
        clr();
        check("wrap_pre", bus.pc, 16'hFFFF);
        tick();
        check("wrap_pc", bus.pc, 16'h0000);
        check("wrap_flush", bus.flush, 0);
        push(16'h1234, 16'h0042);
        #2 rst = 0;
        #1;
        check("arst_pc", bus.pc, 0);
        check("arst_empty", bus.ras_empty, 1);
        check("arst_flush", bus.flush, 0);
        @(negedge clk);
        rst = 1;
        tick();
        check("arst_release_pc", bus.pc, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
